row_buf7_ctrl: RTL

Sequencing controller for the 7-row line-buffer chain (7x7 sliding window). It accepts a raster pixel stream with a valid/ready handshake and start-of-frame marker. It produces the gated shift enable and data that advance the row buffers, and tracks column and row position. It flags which shifts complete a full in-image 7x7 window, and signals frame completion. It sits between the pixel source and the row-buffer chain; window consumers (filters, detectors) qualify their taps with its `win_valid`.

---
 rtl/row_buf7_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/row_buf7_ctrl.sv
// Sequencing controller for a KERNEL-row line-buffer chain: gates the raster stream into the
// buffers, tracks raster position and flags shifts that complete an in-image KERNELxKERNEL window.
module row_buf7_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned KERNEL       = 7,
    localparam int unsigned CW          = $clog2(IMAGE_WIDTH),
    localparam int unsigned RW          = $clog2(IMAGE_HEIGHT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic                  in_sof_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  in_ready_o,
    output logic                  buf_en_o,
    output logic [DATA_WIDTH-1:0] buf_din_o,
    output logic [CW-1:0]         col_o,
    output logic [RW-1:0]         row_o,
    output logic                  win_valid_o,
    output logic [CW-1:0]         cx_o,
    output logic [RW-1:0]         cy_o,
    output logic                  frame_done_o,
    output logic                  sof_err_o
);

    localparam int unsigned HALF = (KERNEL - 1) / 2;

    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] KM1_COL  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] KM1_ROW  = RW'(KERNEL - 1);
    localparam logic [CW-1:0] HALF_COL = CW'(HALF);
    localparam logic [RW-1:0] HALF_ROW = RW'(HALF);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [CW-1:0] nxt_col_q, nxt_col_d;
    logic [RW-1:0] nxt_row_q, nxt_row_d;

    logic          accept, in_run, emit, restart, last, win;
    logic [CW-1:0] e_col;
    logic [RW-1:0] e_row;

    always_comb begin
        accept  = in_valid_i & in_ready_q;
        in_run  = (state_q == ST_RUN);
        emit    = accept & (in_sof_i | in_run);
        restart = accept & in_sof_i & in_run;
        // An sof pixel is always (0,0), whatever position the counters hold.
        e_col   = in_sof_i ? '0 : nxt_col_q;
        e_row   = in_sof_i ? '0 : nxt_row_q;
        last    = in_run & ~in_sof_i & (e_col == LAST_COL) & (e_row == LAST_ROW);
        win     = (e_col >= KM1_COL) & (e_row >= KM1_ROW);
    end

    always_comb begin
        nxt_col_d = nxt_col_q;
        nxt_row_d = nxt_row_q;
        if (emit) begin
            if (e_col == LAST_COL) begin
                nxt_col_d = '0;
                nxt_row_d = e_row + RW'(1);
            end else begin
                nxt_col_d = e_col + CW'(1);
                nxt_row_d = e_row;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (emit) state_d = ST_RUN;
            ST_RUN:  if (emit && last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            nxt_col_q  <= '0;
            nxt_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            nxt_col_q  <= nxt_col_d;
            nxt_row_q  <= nxt_row_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_en_o     <= 1'b0;
            buf_din_o    <= '0;
            col_o        <= '0;
            row_o        <= '0;
            win_valid_o  <= 1'b0;
            cx_o         <= '0;
            cy_o         <= '0;
            frame_done_o <= 1'b0;
            sof_err_o    <= 1'b0;
        end else begin
            buf_en_o     <= emit;
            win_valid_o  <= emit & win;
            cx_o         <= (emit & win) ? (e_col - HALF_COL) : '0;
            cy_o         <= (emit & win) ? (e_row - HALF_ROW) : '0;
            frame_done_o <= emit & last;
            sof_err_o    <= restart;
            if (emit) begin
                buf_din_o <= din_i;
                col_o     <= e_col;
                row_o     <= e_row;
            end
        end
    end

    assign in_ready_o = in_ready_q;

endmodule
